// File: rtl/adiabatic_pclk_sequencer.sv
// adiabatic_pclk_sequencer
// Sequences the four-phase power clocks (clkpos/clkneg rail pairs) of an
// NSTAGE-deep adiabatic pipeline. Each accepted batch injects one phase wave
// per operand into stage 0; waves shift one stage per phase tick, and the
// pipeline is always drained back to all-IDLE so rail charge is recovered.
//
// Handshake: a request is accepted (ack=1) in the same cycle req is seen in
// S_IDLE; req must be held until then and count is sampled in that cycle.
// done pulses once per accepted batch, and busy covers every cycle from the
// one after ack through the done cycle.
//
// Optional feature: define PCLK_PERF_CNT_EN to add the busy_cycles output,
// a saturating count of busy cycles that is cleared on each accept.
module adiabatic_pclk_sequencer #(
    parameter int NSTAGE       = 4,
    parameter int PHASE_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [CNT_W-1:0]      count,
    output logic                  ack,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  inject,
    output logic [2*NSTAGE-1:0]   stage_phase,
    output logic [NSTAGE-1:0]     clkpos_en,
    output logic [NSTAGE-1:0]     clkneg_en,
`ifdef PCLK_PERF_CNT_EN
    output logic [31:0]           busy_cycles,
`endif
    output logic [1:0]            dbg_state
);

    localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

    localparam logic [1:0] PH_IDLE = 2'b00;
    localparam logic [1:0] PH_UP   = 2'b01;
    localparam logic [1:0] PH_HOLD = 2'b10;
    localparam logic [1:0] PH_DOWN = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    tokens_q;
    logic [TW-1:0]       tick_q;
    logic [2*NSTAGE-1:0] phase_q;
    logic [2*NSTAGE-1:0] phase_d;
    logic                busy_q;
    logic                done_q;
    logic                inject_q;

    logic tick_end;
    logic halt_inj;
    logic inj_go;

    // A phase tick happens at the edge that closes the last cycle of a phase.
    assign tick_end = (tick_q == TW'(PHASE_CYCLES - 1));
    // abort only matters while injecting, and it beats a coincident injection.
    assign halt_inj = (state_q == S_RUN) && abort;
    assign inj_go   = (state_q == S_RUN) && !abort && tick_end &&
                      (phase_q[1:0] == PH_IDLE) && (tokens_q != '0);

    // Pipeline contents after the next tick: shift stages up, advance stage 0.
    always_comb begin
        phase_d = phase_q;
        for (int k = 1; k < NSTAGE; k++) begin
            phase_d[2*k +: 2] = phase_q[2*(k-1) +: 2];
        end
        case (phase_q[1:0])
            PH_IDLE: phase_d[1:0] = inj_go ? PH_UP : PH_IDLE;
            PH_UP:   phase_d[1:0] = PH_HOLD;
            PH_HOLD: phase_d[1:0] = PH_DOWN;
            default: phase_d[1:0] = PH_IDLE;
        endcase
    end

    // Batch sequencing FSM with its registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tokens_q <= '0;
            tick_q   <= '0;
            phase_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inject_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        tokens_q <= count;
                        tick_q   <= '0;
                        busy_q   <= 1'b1;
                        if (count != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    tick_q <= tick_end ? '0 : tick_q + TW'(1);
                    if (halt_inj) begin
                        tokens_q <= '0;
                        state_q  <= S_DRAIN;
                    end
                    if (tick_end) begin
                        phase_q <= phase_d;
                        if (inj_go) begin
                            tokens_q <= tokens_q - CNT_W'(1);
                            inject_q <= 1'b1;
                            if (tokens_q == CNT_W'(1)) begin
                                state_q <= S_DRAIN;
                            end
                        end
                        // Finish only once every stage has ramped back to IDLE.
                        if ((state_q == S_DRAIN || halt_inj) && phase_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    tick_q   <= '0;
                    tokens_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Rail enables follow the stage phase: positive rail on during UP/HOLD.
    always_comb begin
        clkpos_en = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            clkpos_en[k] = phase_q[2*k] ^ phase_q[2*k+1];
        end
    end

    assign clkneg_en   = ~clkpos_en;
    assign ack         = (state_q == S_IDLE) && req;
    assign busy        = busy_q;
    assign done        = done_q;
    assign inject      = inject_q;
    assign stage_phase = phase_q;
    assign dbg_state   = state_q;

`ifdef PCLK_PERF_CNT_EN
    logic [31:0] busy_cycles_q;

    // Saturating busy-cycle counter, restarted on every accepted batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles_q <= '0;
        end else if (ack) begin
            busy_cycles_q <= '0;
        end else if (busy_q && (busy_cycles_q != 32'hFFFF_FFFF)) begin
            busy_cycles_q <= busy_cycles_q + 32'd1;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Bench for adiabatic_pclk_sequencer (NSTAGE=4, PHASE_CYCLES=2).
// Cycle 0 is the ack cycle of each batch; outputs are sampled on the falling
// edge and inputs are driven 1 time unit after the rising edge.
module tb_adiabatic_pclk_sequencer;

    localparam int NS       = 4;
    localparam int P        = 2;
    localparam int CW       = 8;
    localparam int NO_ABORT = 1000000;

    logic            clk = 1'b0;
    logic            rst;
    logic            req;
    logic            abort;
    logic [CW-1:0]   count;
    logic            ack;
    logic            busy;
    logic            done;
    logic            inject;
    logic [2*NS-1:0] stage_phase;
    logic [NS-1:0]   clkpos_en;
    logic [NS-1:0]   clkneg_en;
    logic [1:0]      dbg_state;
`ifdef PCLK_PERF_CNT_EN
    logic [31:0]     busy_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int cnt;
        int ab_cyc;
        int done_c;
        int injects;
    } vec_t;

    vec_t tbl[7];

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    adiabatic_pclk_sequencer #(
        .NSTAGE(NS),
        .PHASE_CYCLES(P),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .count(count),
        .ack(ack),
        .abort(abort),
        .busy(busy),
        .done(done),
        .inject(inject),
        .stage_phase(stage_phase),
        .clkpos_en(clkpos_en),
        .clkneg_en(clkneg_en),
`ifdef PCLK_PERF_CNT_EN
        .busy_cycles(busy_cycles),
`endif
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: wave i enters stage 0 at tick 1+4i, reaches stage k k ticks
    // later and spends one tick each in UP, HOLD, DOWN. Ticks seen by cycle c
    // are floor((c-1)/P).
    function automatic logic [18:0] model_vec(input int cyc, input int c_cnt,
                                              input int n_inj, input int done_c);
        logic [2*NS-1:0] ph;
        logic [NS-1:0]   pos;
        logic            inj;
        int              t;
        int              d;
        ph  = '0;
        pos = '0;
        inj = 1'b0;
        if (c_cnt > 0 && cyc >= 1 && cyc <= done_c) begin
            t = (cyc - 1) / P;
            for (int i = 0; i < n_inj; i++) begin
                if ((1 + 4*i)*P + 1 == cyc) inj = 1'b1;
                for (int k = 0; k < NS; k++) begin
                    d = t - (1 + 4*i) - k;
                    if (d >= 0 && d <= 2) ph[2*k +: 2] = 2'(d + 1);
                end
            end
        end
        for (int k = 0; k < NS; k++) begin
            pos[k] = (ph[2*k +: 2] == 2'd1) || (ph[2*k +: 2] == 2'd2);
        end
        return {(cyc >= 1 && cyc <= done_c), (cyc == done_c), inj, ph, pos, ~pos};
    endfunction

    // Driver + per-cycle scoreboard for one batch.
    task automatic run_batch(input int c_cnt, input int ab_cyc,
                             output int done_obs, output int inj_obs);
        int n_exp;
        int done_exp;
        int waited;
        n_exp = 0;
        for (int i = 0; i < c_cnt; i++) begin
            if ((1 + 4*i)*P < ab_cyc) n_exp++;
        end
        if (c_cnt == 0)      done_exp = 1;
        else if (n_exp == 0) done_exp = P + 1;
        else                 done_exp = (4*n_exp + NS - 1)*P + 1;
        done_obs = -1;
        inj_obs  = 0;

        @(posedge clk); #1;
        req   = 1'b1;
        count = CW'(c_cnt);
        abort = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!ack && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("ack", 64'(ack), 64'd1);
        if (!ack) begin
            req = 1'b0;
            return;
        end

        for (int cyc = 1; cyc <= done_exp + 2; cyc++) begin
            @(posedge clk); #1;
            req   = 1'b0;
            abort = (cyc == ab_cyc);
            @(negedge clk);
            check($sformatf("cycle%0d_cnt%0d", cyc, c_cnt),
                  64'({busy, done, inject, stage_phase, clkpos_en, clkneg_en}),
                  64'(model_vec(cyc, c_cnt, n_exp, done_exp)));
            if (done && done_obs < 0) done_obs = cyc;
            if (inject) inj_obs++;
`ifdef PCLK_PERF_CNT_EN
            if (cyc == 1) check("perf_cleared", 64'(busy_cycles), 64'd0);
`endif
        end
        abort = 1'b0;
`ifdef PCLK_PERF_CNT_EN
        check("perf_total", 64'(busy_cycles), 64'(done_exp));
`endif
    endtask

    initial begin
        int d_obs;
        int i_obs;
        int c_r;
        int a_r;

        tbl[0] = '{cnt: 1, ab_cyc: NO_ABORT, done_c: 15, injects: 1};
        tbl[1] = '{cnt: 2, ab_cyc: NO_ABORT, done_c: 23, injects: 2};
        tbl[2] = '{cnt: 0, ab_cyc: NO_ABORT, done_c: 1,  injects: 0};
        tbl[3] = '{cnt: 5, ab_cyc: 12,       done_c: 23, injects: 2};
        tbl[4] = '{cnt: 3, ab_cyc: NO_ABORT, done_c: 31, injects: 3};
        tbl[5] = '{cnt: 3, ab_cyc: 10,       done_c: 15, injects: 1};
        tbl[6] = '{cnt: 4, ab_cyc: 1,        done_c: 3,  injects: 0};

        // reset
        rst   = 1'b1;
        req   = 1'b0;
        abort = 1'b0;
        count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({ack, busy, done, inject, stage_phase, clkpos_en, clkneg_en, dbg_state}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'hF, 2'b00}));
        @(posedge clk); #1;
        rst = 1'b0;

        // table-driven batches
        for (int v = 0; v < 7; v++) begin
            run_batch(tbl[v].cnt, tbl[v].ab_cyc, d_obs, i_obs);
            check($sformatf("tbl%0d_done_cycle", v), 64'(d_obs), 64'(tbl[v].done_c));
            check($sformatf("tbl%0d_injects", v), 64'(i_obs), 64'(tbl[v].injects));
        end

        // reset in the middle of a run with stages in UP/HOLD
        @(posedge clk); #1;
        req   = 1'b1;
        count = 8'd3;
        @(negedge clk);
        check("mid_ack", 64'(ack), 64'd1);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            req = 1'b0;
        end
        @(negedge clk);
        check("mid_phase_before_rst", 64'(stage_phase), 64'h06);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_phase", 64'(stage_phase), 64'h00);
        check("mid_rst_rails", 64'({clkpos_en, clkneg_en}), 64'h0F);
        check("mid_rst_status", 64'({busy, done, inject, dbg_state}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_batch(1, NO_ABORT, d_obs, i_obs);
        check("post_rst_done_cycle", 64'(d_obs), 64'd15);

        // randomized batches against the reference model
        for (int r = 0; r < 10; r++) begin
            c_r = $urandom_range(0, 6);
            a_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (4*c_r + NS)*P + 2) : NO_ABORT;
            run_batch(c_r, a_r, d_obs, i_obs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
